// File: rtl/timer_multi_ch.sv
// Multi-channel APB timer: NUM_CH up/down counters with per-channel reload, prescaler,
// sticky overflow/underflow flags and masked level interrupts.
module timer_multi_ch #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);
    localparam int NB = CNT_WIDTH / 8;
    // Byte 0 of a CNT read is always live, so the snapshot only holds the upper bytes.
    localparam int SW = (CNT_WIDTH > 8) ? CNT_WIDTH : 16;

    logic [CNT_WIDTH-1:0] tdr  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt  [NUM_CH];
    logic [SW-9:0]        snap [NUM_CH];
    logic [7:0]           pre  [NUM_CH];
    logic [2:0]           cks  [NUM_CH];
    logic [NUM_CH-1:0]    load, arl, dn, en, ovf, udf, ovf_ie, udf_ie;
    logic [NUM_CH-1:0]    hit, tcr_wr, tsr_wr, tick, ovf_set, udf_set;

    logic [3:0] ch_sel;
    logic [3:0] off;
    logic       off_ok, err, acc, wr_ok, rd_ok;

    assign ch_sel  = paddr[7:4];
    assign off     = paddr[3:0];
    assign acc     = psel & penable;
    assign wr_ok   = acc & pwrite & ~err;
    assign rd_ok   = acc & ~pwrite & ~err;
    assign pready  = 1'b1;
    assign pslverr = acc & err;

    always_comb begin
        off_ok = 1'b0;
        case (off)
            4'h0, 4'h1, 4'h2, 4'h3: off_ok = (int'(off) < NB);
            4'h4, 4'h5, 4'h6:       off_ok = 1'b1;
            4'h8, 4'h9, 4'hA, 4'hB: off_ok = ((int'(off) - 8) < NB);
            default:                off_ok = 1'b0;
        endcase
        err = (int'(ch_sel) >= NUM_CH) | ~off_ok;
    end

    always_comb begin
        hit     = '0;
        tcr_wr  = '0;
        tsr_wr  = '0;
        tick    = '0;
        ovf_set = '0;
        udf_set = '0;
        irq     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c]     = (ch_sel == 4'(c));
            tcr_wr[c]  = wr_ok & hit[c] & (off == 4'h4);
            tsr_wr[c]  = wr_ok & hit[c] & (off == 4'h5);
            tick[c]    = en[c] & ~load[c] & ({1'b0, pre[c]} == ((9'd2 << cks[c]) - 9'd1));
            ovf_set[c] = tick[c] & ~dn[c] & (cnt[c] == '1);
            udf_set[c] = tick[c] & dn[c] & (cnt[c] == '0);
            irq[c]     = (ovf[c] & ovf_ie[c]) | (udf[c] & udf_ie[c]);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tdr[c]  <= '0;
                cnt[c]  <= '0;
                snap[c] <= '0;
                pre[c]  <= '0;
                cks[c]  <= '0;
            end
            load   <= '0;
            arl    <= '0;
            dn     <= '0;
            en     <= '0;
            ovf    <= '0;
            udf    <= '0;
            ovf_ie <= '0;
            udf_ie <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ok && hit[c]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (off == 4'(b)) tdr[c][8*b +: 8] <= pwdata;
                    end
                    case (off)
                        4'h4: begin
                            load[c] <= pwdata[7];
                            arl[c]  <= pwdata[6];
                            dn[c]   <= pwdata[5];
                            en[c]   <= pwdata[4];
                            cks[c]  <= pwdata[2:0];
                        end
                        4'h6: begin
                            ovf_ie[c] <= pwdata[0];
                            udf_ie[c] <= pwdata[1];
                        end
                        default: ;
                    endcase
                end

                if (tcr_wr[c] || !en[c] || load[c] || tick[c]) pre[c] <= '0;
                else                                           pre[c] <= pre[c] + 8'd1;

                if (load[c]) begin
                    cnt[c] <= tdr[c];
                end else if (tick[c]) begin
                    if (!dn[c]) cnt[c] <= ovf_set[c] ? (arl[c] ? tdr[c] : '0) : cnt[c] + CNT_WIDTH'(1);
                    else        cnt[c] <= udf_set[c] ? (arl[c] ? tdr[c] : '1) : cnt[c] - CNT_WIDTH'(1);
                end

                // A set on the same edge as a write-one-to-clear wins.
                ovf[c] <= ovf_set[c] | (ovf[c] & ~(tsr_wr[c] & pwdata[0]));
                udf[c] <= udf_set[c] | (udf[c] & ~(tsr_wr[c] & pwdata[1]));

                if (rd_ok && hit[c] && off == 4'h8) snap[c] <= (SW-8)'(SW'(cnt[c]) >> 8);
            end
        end
    end

    always_comb begin
        prdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ok && hit[c]) begin
                for (int b = 0; b < NB; b++) begin
                    if (off == 4'(b)) prdata = tdr[c][8*b +: 8];
                end
                for (int b = 1; b < NB; b++) begin
                    if (off == 4'(8 + b)) prdata = snap[c][8*(b-1) +: 8];
                end
                case (off)
                    4'h4:    prdata = {load[c], arl[c], dn[c], en[c], 1'b0, cks[c]};
                    4'h5:    prdata = {6'b0, udf[c], ovf[c]};
                    4'h6:    prdata = {6'b0, udf_ie[c], ovf_ie[c]};
                    4'h8:    prdata = cnt[c][7:0];
                    default: ;
                endcase
            end
        end
    end
endmodule
